add_seq_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit full-adder carry chain between two requesters. Each transaction adds two WORDS-byte operands and a carry-in, processing one byte per cycle, least-significant byte first. The carry is registered between bytes and the result is returned over a valid/ready response channel. It sits between two client datapaths and the single ripple-carry adder resource, so wide additions cost a few cycles instead of a wide adder.

---
 rtl/add_seq_arbiter.sv | 116 +++++++++++
 tb/tb_add_seq_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_arbiter.sv
// Two-requester round-robin front end sharing one 8-bit adder; operands are
// summed one byte per cycle, least-significant byte first, with a registered carry.
module add_seq_arbiter #(
  parameter int WORDS = 4
) (
  input  logic               CLK,
  input  logic               ASYNCRESETN,
  input  logic               REQ0_VALID,
  output logic               REQ0_READY,
  input  logic [8*WORDS-1:0] REQ0_A,
  input  logic [8*WORDS-1:0] REQ0_B,
  input  logic               REQ0_CIN,
  input  logic               REQ1_VALID,
  output logic               REQ1_READY,
  input  logic [8*WORDS-1:0] REQ1_A,
  input  logic [8*WORDS-1:0] REQ1_B,
  input  logic               REQ1_CIN,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic               RSP_ID,
  output logic [8*WORDS-1:0] RSP_SUM,
  output logic               RSP_COUT
);
  // state | meaning
  // IDLE  | arbitrate and accept one request
  // ADD   | add byte k of the latched operands
  // DONE  | hold the result until the response handshake
  typedef enum logic [1:0] {IDLE, ADD, DONE} stateT;

  localparam int nBits  = 8 * WORDS;
  localparam int kWidth = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [kWidth-1:0] kLast = kWidth'(WORDS - 1);

  stateT             state;
  stateT             stateNext;
  logic              lastGrant;
  logic              grant0;
  logic              grant1;
  logic [nBits-1:0]  opA;
  logic [nBits-1:0]  opB;
  logic              carry;
  logic [nBits-1:0]  sumReg;
  logic              coutReg;
  logic              idReg;
  logic [kWidth-1:0] k;
  logic [kWidth+2:0] byteIdx;
  logic [8:0]        byteSum;

  // Requester 0 wins a conflict when 1 was granted last; a lone request always wins.
  assign grant0  = REQ0_VALID && (!REQ1_VALID || lastGrant);
  assign grant1  = REQ1_VALID && !grant0;
  assign byteIdx = {k, 3'b000};
  assign byteSum = {1'b0, opA[byteIdx +: 8]} + {1'b0, opB[byteIdx +: 8]} + {8'b0, carry};

  assign RSP_ID   = idReg;
  assign RSP_SUM  = sumReg;
  assign RSP_COUT = coutReg;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      opA       <= '0;
      opB       <= '0;
      carry     <= 1'b0;
      sumReg    <= '0;
      coutReg   <= 1'b0;
      idReg     <= 1'b0;
      k         <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            opA       <= grant1 ? REQ1_A : REQ0_A;
            opB       <= grant1 ? REQ1_B : REQ0_B;
            carry     <= grant1 ? REQ1_CIN : REQ0_CIN;
            idReg     <= grant1;
            lastGrant <= grant1;
            k         <= '0;
          end
        end
        ADD: begin
          sumReg[byteIdx +: 8] <= byteSum[7:0];
          carry                <= byteSum[8];
          k                    <= k + kWidth'(1);
          if (k == kLast) coutReg <= byteSum[8];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext  = state;
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    RSP_VALID  = 1'b0;
    case (state)
      IDLE: begin
        // Ready is gated by reset so nothing looks accepted while held in reset.
        REQ0_READY = ASYNCRESETN && grant0;
        REQ1_READY = ASYNCRESETN && grant1;
        if (grant0 || grant1) stateNext = ADD;
      end
      ADD: begin
        if (k == kLast) stateNext = DONE;
      end
      DONE: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end
endmodule

// File: tb/tb_add_seq_arbiter.sv
// Randomized self-checking bench for add_seq_arbiter: a queue-based round-robin and
// wide-addition model predicts grants and responses; a WORDS=1 instance is also covered.
`timescale 1ns/1ps
module tb_add_seq_arbiter;
  localparam int W = 4;
  localparam int N = 8 * W;

  typedef struct { logic id; int cyc; } gntT;
  typedef struct { logic id; logic [N-1:0] sum; logic cout; int cyc; } rspT;
  typedef struct { logic id; logic [N-1:0] a; logic [N-1:0] b; logic c; } opT;

  logic CLK = 1'b0;
  logic rstN = 1'b0;
  logic req0Valid = 1'b0, req1Valid = 1'b0, req0Cin = 1'b0, req1Cin = 1'b0, rspReady = 1'b0;
  logic [N-1:0] req0A = '0, req0B = '0, req1A = '0, req1B = '0;
  logic req0Ready, req1Ready, rspValid, rspId, rspCout;
  logic [N-1:0] rspSum;

  logic s1Valid = 1'b0, s1Cin = 1'b0;
  logic [7:0] s1A = '0, s1B = '0;
  logic s1Ready, s1Ready1, s1RspValid, s1RspId, s1RspCout;
  logic [7:0] s1RspSum;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  gntT grantQ[$];
  rspT rspQ[$];

  add_seq_arbiter #(.WORDS(W)) dut (
    .CLK(CLK), .ASYNCRESETN(rstN),
    .REQ0_VALID(req0Valid), .REQ0_READY(req0Ready), .REQ0_A(req0A), .REQ0_B(req0B), .REQ0_CIN(req0Cin),
    .REQ1_VALID(req1Valid), .REQ1_READY(req1Ready), .REQ1_A(req1A), .REQ1_B(req1B), .REQ1_CIN(req1Cin),
    .RSP_VALID(rspValid), .RSP_READY(rspReady), .RSP_ID(rspId), .RSP_SUM(rspSum), .RSP_COUT(rspCout)
  );

  add_seq_arbiter #(.WORDS(1)) dut1 (
    .CLK(CLK), .ASYNCRESETN(rstN),
    .REQ0_VALID(s1Valid), .REQ0_READY(s1Ready), .REQ0_A(s1A), .REQ0_B(s1B), .REQ0_CIN(s1Cin),
    .REQ1_VALID(1'b0), .REQ1_READY(s1Ready1), .REQ1_A(8'h00), .REQ1_B(8'h00), .REQ1_CIN(1'b0),
    .RSP_VALID(s1RspValid), .RSP_READY(1'b1), .RSP_ID(s1RspId), .RSP_SUM(s1RspSum), .RSP_COUT(s1RspCout)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Handshakes are recorded half a cycle before the edge that completes them.
  always @(negedge CLK) begin
    if (req0Valid && req0Ready) grantQ.push_back('{1'b0, cyc});
    if (req1Valid && req1Ready) grantQ.push_back('{1'b1, cyc});
    if (rspValid && rspReady) rspQ.push_back('{rspId, rspSum, rspCout, cyc});
  end

  function automatic logic [N:0] refAdd(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
  endfunction

  function automatic opT randOp(input logic id);
    opT o;
    o.id = id;
    o.a  = $urandom;
    o.b  = $urandom;
    o.c  = 1'($urandom_range(0, 1));
    return o;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input opT o);
    if (o.id == 1'b0) begin
      req0Valid = 1'b1; req0A = o.a; req0B = o.b; req0Cin = o.c;
    end else begin
      req1Valid = 1'b1; req1A = o.a; req1B = o.b; req1Cin = o.c;
    end
  endtask

  task automatic pulseReset();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    grantQ.delete();
    rspQ.delete();
  endtask

  // Holds pending requests until each is accepted, as a well-behaved requester does.
  task automatic serve(input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      bit r0, r1;
      if (!req0Valid && !req1Valid) break;
      #1;
      r0 = req0Valid && req0Ready;
      r1 = req1Valid && req1Ready;
      tick();
      if (r0) req0Valid = 1'b0;
      if (r1) req1Valid = 1'b0;
    end
    ok = !req0Valid && !req1Valid;
    req0Valid = 1'b0;
    req1Valid = 1'b0;
  endtask

  task automatic waitRsp(input int want, input int budget, output bit ok);
    for (int i = 0; i < budget && rspQ.size() < want; i++) tick();
    ok = (rspQ.size() >= want);
  endtask

  task automatic waitValid(input int budget, output int riseCyc, output bit ok);
    ok = 1'b0;
    riseCyc = 0;
    for (int i = 0; i < budget; i++) begin
      if (rspValid) begin
        ok = 1'b1;
        riseCyc = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; req0Valid = 1'b1; req1Valid = 1'b1; rspReady = 1'b1;
    #3;
    vectors++; if (rspValid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rspValid); end
    vectors++; if (rspSum !== '0) begin miscompares++; $display("FAIL reset_rsp_sum: got %h want 0", rspSum); end
    vectors++; if (rspCout !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_cout: got %b want 0", rspCout); end
    vectors++; if (rspId !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_id: got %b want 0", rspId); end
    vectors++; if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready: got %b%b want 00", req0Ready, req1Ready);
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    grantQ.delete();
    rspQ.delete();
  endtask

  task automatic test_basic();
    opT o; int acc, rise; bit ok; logic [N:0] e;
    o.id = 1'b0; o.a = 32'h0000_00FF; o.b = 32'h0000_0001; o.c = 1'b0;
    e = refAdd(o.a, o.b, o.c);
    drive(o);
    #1;
    vectors++; if (req0Ready !== 1'b1) begin miscompares++; $display("FAIL first_accept_after_reset: got %b want 1", req0Ready); end
    tick();
    acc = cyc;
    req0Valid = 1'b0;
    waitValid(20, rise, ok);
    vectors++; if (!ok || rise - acc != W) begin
      miscompares++; $display("FAIL basic_latency: got %0d want %0d (seen %b)", rise - acc, W, ok);
    end
    waitRsp(1, 20, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL basic_rsp: got none want 1"); end
    else begin
      vectors++; if (rspQ[0].sum !== e[N-1:0]) begin miscompares++; $display("FAIL basic_sum: got %h want %h", rspQ[0].sum, e[N-1:0]); end
      vectors++; if (rspQ[0].cout !== e[N] || rspQ[0].id !== 1'b0) begin
        miscompares++; $display("FAIL basic_cout_id: got %b/%b want %b/0", rspQ[0].cout, rspQ[0].id, e[N]);
      end
    end
    rspQ.delete();
    grantQ.delete();
  endtask

  task automatic test_ripple();
    opT o; bit ok; logic [N:0] e;
    o.id = 1'b1; o.a = 32'hFFFF_FFFF; o.b = 32'h0; o.c = 1'b1;
    e = refAdd(o.a, o.b, o.c);
    drive(o);
    serve(20, ok);
    waitRsp(1, 30, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL ripple_rsp: got none want 1"); end
    else begin
      vectors++; if (rspQ[0].sum !== e[N-1:0] || rspQ[0].cout !== e[N]) begin
        miscompares++; $display("FAIL ripple_sum: got %h/%b want %h/%b", rspQ[0].sum, rspQ[0].cout, e[N-1:0], e[N]);
      end
      vectors++; if (rspQ[0].id !== 1'b1) begin miscompares++; $display("FAIL ripple_id: got %b want 1", rspQ[0].id); end
    end
    rspQ.delete();
    grantQ.delete();
  endtask

  task automatic test_conflict();
    opT o0, o1; bit ok; logic [N:0] e0, e1;
    pulseReset();
    rspReady = 1'b1;
    o0.id = 1'b0; o0.a = 32'h1;  o0.b = 32'h2;  o0.c = 1'b0;
    o1.id = 1'b1; o1.a = 32'h10; o1.b = 32'h20; o1.c = 1'b0;
    e0 = refAdd(o0.a, o0.b, o0.c);
    e1 = refAdd(o1.a, o1.b, o1.c);
    drive(o0);
    drive(o1);
    serve(40, ok);
    vectors++; if (!ok || grantQ.size() != 2) begin
      miscompares++; $display("FAIL conflict_grants: got %0d want 2", grantQ.size());
    end else begin
      vectors++; if (grantQ[0].id !== 1'b0 || grantQ[1].id !== 1'b1) begin
        miscompares++; $display("FAIL conflict_order: got %b,%b want 0,1", grantQ[0].id, grantQ[1].id);
      end
    end
    waitRsp(2, 40, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL conflict_rsp: got %0d want 2", rspQ.size()); end
    else begin
      vectors++; if (rspQ[0].sum !== e0[N-1:0] || rspQ[0].id !== 1'b0) begin
        miscompares++; $display("FAIL conflict_rsp0: got %h/%b want %h/0", rspQ[0].sum, rspQ[0].id, e0[N-1:0]);
      end
      vectors++; if (rspQ[1].sum !== e1[N-1:0] || rspQ[1].id !== 1'b1) begin
        miscompares++; $display("FAIL conflict_rsp1: got %h/%b want %h/1", rspQ[1].sum, rspQ[1].id, e1[N-1:0]);
      end
    end
    rspQ.delete();
    grantQ.delete();
  endtask

  task automatic test_alternate();
    opT ops[2][4]; opT expQ[$]; int rem[2]; int idx[2]; logic ptr; logic g; bit r0, r1; bit ok; logic [N:0] e;
    rspReady = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) ops[r][i] = randOp(r == 1);
    rem = '{4, 4};
    ptr = 1'b1;
    while (rem[0] + rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) g = !ptr;
      else g = (rem[0] > 0) ? 1'b0 : 1'b1;
      expQ.push_back(ops[g][4 - rem[g]]);
      rem[g]--;
      ptr = g;
    end
    idx = '{0, 0};
    drive(ops[0][0]);
    drive(ops[1][0]);
    for (int i = 0; i < 300 && (req0Valid || req1Valid); i++) begin
      #1;
      r0 = req0Valid && req0Ready;
      r1 = req1Valid && req1Ready;
      tick();
      if (r0) begin idx[0]++; if (idx[0] < 4) drive(ops[0][idx[0]]); else req0Valid = 1'b0; end
      if (r1) begin idx[1]++; if (idx[1] < 4) drive(ops[1][idx[1]]); else req1Valid = 1'b0; end
    end
    waitRsp(8, 100, ok);
    vectors++; if (!ok || grantQ.size() != 8) begin
      miscompares++; $display("FAIL alternate_count: got %0d/%0d want 8/8", grantQ.size(), rspQ.size());
    end
    for (int i = 0; i < 8; i++) begin
      if (i < grantQ.size() && i < rspQ.size()) begin
        e = refAdd(expQ[i].a, expQ[i].b, expQ[i].c);
        vectors++; if (grantQ[i].id !== expQ[i].id || rspQ[i].id !== expQ[i].id) begin
          miscompares++; $display("FAIL alternate_id[%0d]: got %b/%b want %b", i, grantQ[i].id, rspQ[i].id, expQ[i].id);
        end
        vectors++; if (rspQ[i].sum !== e[N-1:0] || rspQ[i].cout !== e[N]) begin
          miscompares++; $display("FAIL alternate_sum[%0d]: got %h/%b want %h/%b", i, rspQ[i].sum, rspQ[i].cout, e[N-1:0], e[N]);
        end
      end
    end
    rspQ.delete();
    grantQ.delete();
  endtask

  task automatic test_backpressure();
    opT o, x0, x1; int rise; bit ok; logic [N:0] e, e0, e1;
    rspReady = 1'b0;
    o = randOp(1'b0);
    e = refAdd(o.a, o.b, o.c);
    drive(o);
    serve(20, ok);
    waitValid(20, rise, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_valid: got 0 want 1"); end
    x0 = randOp(1'b0);
    x1 = randOp(1'b1);
    e0 = refAdd(x0.a, x0.b, x0.c);
    e1 = refAdd(x1.a, x1.b, x1.c);
    drive(x0);
    drive(x1);
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++; if (rspValid !== 1'b1 || rspId !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold_valid[%0d]: got %b/%b want 1/0", i, rspValid, rspId);
      end
      vectors++; if (rspSum !== e[N-1:0] || rspCout !== e[N]) begin
        miscompares++; $display("FAIL bp_hold_sum[%0d]: got %h/%b want %h/%b", i, rspSum, rspCout, e[N-1:0], e[N]);
      end
      vectors++; if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_ready[%0d]: got %b%b want 00", i, req0Ready, req1Ready);
      end
      tick();
    end
    rspReady = 1'b1;
    serve(60, ok);
    waitRsp(3, 60, ok);
    vectors++; if (!ok || grantQ.size() != 3) begin
      miscompares++; $display("FAIL bp_counts: got %0d/%0d want 3/3", grantQ.size(), rspQ.size());
    end else begin
      vectors++; if (grantQ[1].cyc - rspQ[0].cyc != 1) begin
        miscompares++; $display("FAIL bp_next_accept: got %0d want 1", grantQ[1].cyc - rspQ[0].cyc);
      end
      vectors++; if (grantQ[1].id !== 1'b1 || grantQ[2].id !== 1'b0) begin
        miscompares++; $display("FAIL bp_order: got %b,%b want 1,0", grantQ[1].id, grantQ[2].id);
      end
      vectors++; if (rspQ[0].sum !== e[N-1:0] || rspQ[1].sum !== e1[N-1:0] || rspQ[2].sum !== e0[N-1:0]) begin
        miscompares++; $display("FAIL bp_sums: got %h,%h,%h want %h,%h,%h", rspQ[0].sum, rspQ[1].sum, rspQ[2].sum,
                                e[N-1:0], e1[N-1:0], e0[N-1:0]);
      end
    end
    rspQ.delete();
    grantQ.delete();
  endtask

  task automatic test_reset_mid();
    opT o, n0, n1; bit ok; logic [N:0] e0, e1;
    rspReady = 1'b1;
    o = randOp(1'b0);
    drive(o);
    serve(20, ok);
    tick();
    tick();
    rstN = 1'b0;
    n0 = randOp(1'b0);
    n1 = randOp(1'b1);
    e0 = refAdd(n0.a, n0.b, n0.c);
    e1 = refAdd(n1.a, n1.b, n1.c);
    drive(n0);
    drive(n1);
    #1;
    vectors++; if (rspValid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b want 0", rspValid); end
    vectors++; if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin
      miscompares++; $display("FAIL midreset_ready: got %b%b want 00", req0Ready, req1Ready);
    end
    tick();
    tick();
    rstN = 1'b1;
    serve(40, ok);
    waitRsp(2, 60, ok);
    for (int i = 0; i < 12; i++) tick();
    vectors++; if (grantQ.size() != 3 || rspQ.size() != 2) begin
      miscompares++; $display("FAIL midreset_counts: got %0d/%0d want 3/2", grantQ.size(), rspQ.size());
    end else begin
      vectors++; if (grantQ[1].id !== 1'b0) begin miscompares++; $display("FAIL midreset_first_grant: got %b want 0", grantQ[1].id); end
      vectors++; if (rspQ[0].id !== 1'b0 || rspQ[0].sum !== e0[N-1:0]) begin
        miscompares++; $display("FAIL midreset_rsp0: got %b/%h want 0/%h", rspQ[0].id, rspQ[0].sum, e0[N-1:0]);
      end
      vectors++; if (rspQ[1].id !== 1'b1 || rspQ[1].sum !== e1[N-1:0]) begin
        miscompares++; $display("FAIL midreset_rsp1: got %b/%h want 1/%h", rspQ[1].id, rspQ[1].sum, e1[N-1:0]);
      end
    end
    rspQ.delete();
    grantQ.delete();
  endtask

  task automatic test_random();
    opT expQ[$]; opT p[2]; bit v[2]; logic ptr; logic g; bit r0, r1; bit ok; logic [N:0] e;
    pulseReset();
    ptr = 1'b1;
    for (int rnd = 0; rnd < 12; rnd++) begin
      v[0] = 1'($urandom_range(0, 1));
      v[1] = 1'($urandom_range(0, 1));
      if (!v[0] && !v[1]) v[$urandom_range(0, 1)] = 1'b1;
      p[0] = randOp(1'b0);
      p[1] = randOp(1'b1);
      if (v[0] && v[1]) begin
        g = !ptr;
        expQ.push_back(p[g]);
        expQ.push_back(p[!g]);
        ptr = !g;
      end else begin
        g = v[1];
        expQ.push_back(p[g]);
        ptr = g;
      end
      if (v[0]) drive(p[0]);
      if (v[1]) drive(p[1]);
      for (int i = 0; i < 200 && (req0Valid || req1Valid); i++) begin
        #1;
        r0 = req0Valid && req0Ready;
        r1 = req1Valid && req1Ready;
        tick();
        if (r0) req0Valid = 1'b0;
        if (r1) req1Valid = 1'b0;
        rspReady = 1'($urandom_range(0, 1));
      end
      vectors++; if (req0Valid || req1Valid) begin
        miscompares++; $display("FAIL random_accept_timeout[%0d]: got pending want none", rnd);
      end
      req0Valid = 1'b0;
      req1Valid = 1'b0;
    end
    rspReady = 1'b1;
    waitRsp(expQ.size(), 200, ok);
    vectors++; if (!ok || rspQ.size() != expQ.size()) begin
      miscompares++; $display("FAIL random_count: got %0d want %0d", rspQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < rspQ.size() && i < grantQ.size()) begin
        e = refAdd(expQ[i].a, expQ[i].b, expQ[i].c);
        vectors++; if (grantQ[i].id !== expQ[i].id || rspQ[i].id !== expQ[i].id || rspQ[i].sum !== e[N-1:0] || rspQ[i].cout !== e[N]) begin
          miscompares++; $display("FAIL random_rsp[%0d]: got %b/%b/%h/%b want %b/%h/%b", i, grantQ[i].id, rspQ[i].id,
                                  rspQ[i].sum, rspQ[i].cout, expQ[i].id, e[N-1:0], e[N]);
        end
      end
    end
    rspQ.delete();
    grantQ.delete();
  endtask

  task automatic test_single_byte();
    logic [7:0] av[2]; logic [7:0] bv[2]; logic cv[2]; logic [8:0] e; int acc, rise;
    av = '{8'h80, 8'h7F};
    bv = '{8'h80, 8'h00};
    cv = '{1'b0, 1'b1};
    for (int t = 0; t < 2; t++) begin
      e = {1'b0, av[t]} + {1'b0, bv[t]} + {8'b0, cv[t]};
      s1A = av[t]; s1B = bv[t]; s1Cin = cv[t]; s1Valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (s1Ready) break;
        tick();
      end
      vectors++; if (s1Ready !== 1'b1) begin miscompares++; $display("FAIL w1_accept[%0d]: got %b want 1", t, s1Ready); end
      tick();
      acc = cyc;
      s1Valid = 1'b0;
      for (int i = 0; i < 20 && !s1RspValid; i++) tick();
      rise = cyc;
      vectors++; if (s1RspValid !== 1'b1 || rise - acc != 1) begin
        miscompares++; $display("FAIL w1_latency[%0d]: got %0d (valid %b) want 1", t, rise - acc, s1RspValid);
      end
      vectors++; if (s1RspSum !== e[7:0] || s1RspCout !== e[8] || s1RspId !== 1'b0) begin
        miscompares++; $display("FAIL w1_sum[%0d]: got %h/%b/%b want %h/%b/0", t, s1RspSum, s1RspCout, s1RspId, e[7:0], e[8]);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_conflict();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_single_byte();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
